// File: rtl/player_button_encoder.sv
// Colour push-button front-end: 2-flop synchroniser and counter debounce per button,
// then a one-shot encoder that reports a single clean press and flags multi-button presses.
module player_button_encoder #(
    parameter int COLOR_CODEFY_W  = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_red,
    input  logic                      btn_green,
    input  logic                      btn_blue,
    input  logic                      btn_yellow,
    input  logic                      enable,
    output logic [COLOR_CODEFY_W-1:0] player_button,
    output logic                      press_valid,
    output logic                      multi_press,
    output logic                      any_pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REPORT,
        WAIT_RELEASE
    } state_t;

    // Bit order: red=0, green=1, blue=2, yellow=3 (matches the colour code).
    logic [3:0] raw;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] deb;

    assign raw = {btn_yellow, btn_blue, btn_green, btn_red};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic             level;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level <= 1'b0;
                cnt   <= '0;
            end else if (s2[g] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2[g];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign deb[g] = level;
    end

    logic                      single;
    logic                      several;
    logic [COLOR_CODEFY_W-1:0] press_code;

    assign any_pressed = |deb;
    assign single      = (deb != '0) && ((deb & (deb - 4'd1)) == '0);
    assign several     = any_pressed && !single;

    always_comb begin
        press_code = '0;
        case (deb)
            4'b0001: press_code = COLOR_CODEFY_W'(0);
            4'b0010: press_code = COLOR_CODEFY_W'(1);
            4'b0100: press_code = COLOR_CODEFY_W'(2);
            4'b1000: press_code = COLOR_CODEFY_W'(3);
            default: press_code = '0;
        endcase
    end

    state_t                    state;
    state_t                    state_next;
    logic [COLOR_CODEFY_W-1:0] code_next;
    logic                      valid_next;
    logic                      multi_next;

    always_comb begin
        state_next = state;
        code_next  = player_button;
        valid_next = 1'b0;
        multi_next = 1'b0;
        case (state)
            IDLE: begin
                if (several) begin
                    state_next = WAIT_RELEASE;
                    multi_next = 1'b1;
                end else if (single) begin
                    if (enable) begin
                        state_next = REPORT;
                        code_next  = press_code;
                        valid_next = 1'b1;
                    end else begin
                        state_next = WAIT_RELEASE;
                    end
                end
            end
            REPORT:       state_next = WAIT_RELEASE;
            WAIT_RELEASE: if (deb == '0) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // Strobes are registered off the transition so they coincide with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            player_button <= '0;
            press_valid   <= 1'b0;
            multi_press   <= 1'b0;
        end else begin
            state         <= state_next;
            player_button <= code_next;
            press_valid   <= valid_next;
            multi_press   <= multi_next;
        end
    end

endmodule

// File: tb/tb_player_button_encoder.sv
// Directed bench for player_button_encoder: a table of single-press vectors plus
// hand-written sequences for bounce, enable gating, late second button and mid-press reset.
module tb_player_button_encoder;

    localparam int D   = 16;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_red = 1'b0;
    logic       btn_green = 1'b0;
    logic       btn_blue = 1'b0;
    logic       btn_yellow = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] player_button;
    logic       press_valid;
    logic       multi_press;
    logic       any_pressed;

    always #5 clk = ~clk;

    player_button_encoder #(
        .COLOR_CODEFY_W (2),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_red      (btn_red),
        .btn_green    (btn_green),
        .btn_blue     (btn_blue),
        .btn_yellow   (btn_yellow),
        .enable       (enable),
        .player_button(player_button),
        .press_valid  (press_valid),
        .multi_press  (multi_press),
        .any_pressed  (any_pressed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc;
    int pv_cnt;
    int pv_first;
    int mp_cnt;
    int ev_first;

    typedef struct {
        logic [3:0] btns;   // {yellow, blue, green, red}
        logic       en;
        int         hold;
        int         exp_pv;
        int         exp_code;
        int         exp_mp;
        int         exp_first;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task clear_mon();
        cyc      = 0;
        pv_cnt   = 0;
        pv_first = 0;
        mp_cnt   = 0;
        ev_first = 0;
    endtask

    task tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_valid === 1'b1) begin
            pv_cnt++;
            if (pv_first == 0) pv_first = cyc;
        end
        if (multi_press === 1'b1) mp_cnt++;
        if ((press_valid === 1'b1 || multi_press === 1'b1) && ev_first == 0) ev_first = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_yellow, btn_blue, btn_green, btn_red} = b;
    endtask

    initial begin
        vecs[0] = '{4'b0100, 1'b1, 40, 1, 2, 0, LAT};
        vecs[1] = '{4'b1001, 1'b1, 30, 0, 2, 1, LAT};
        vecs[2] = '{4'b0010, 1'b0, 30, 0, 2, 0, 0};
        vecs[3] = '{4'b1000, 1'b1, 40, 1, 3, 0, LAT};
        vecs[4] = '{4'b0111, 1'b0, 30, 0, 3, 1, LAT};
        vecs[5] = '{4'b0001, 1'b1, D - 1, 0, 3, 0, 0};
        vecs[6] = '{4'b0001, 1'b1, D, 1, 0, 0, LAT};
        vecs[7] = '{4'b0110, 1'b1, 30, 0, 0, 1, LAT};

        clear_mon();
        run(3);
        chk("reset_player_button", int'(player_button), 0);
        chk("reset_press_valid", int'(press_valid), 0);
        chk("reset_multi_press", int'(multi_press), 0);
        chk("reset_any_pressed", int'(any_pressed), 0);
        rst_n = 1'b1;
        run(3);

        for (int v = 0; v < 8; v++) begin
            enable = vecs[v].en;
            clear_mon();
            set_btns(vecs[v].btns);
            for (int t = 1; t <= 70; t++) begin
                tick();
                if (t == vecs[v].hold) set_btns(4'b0000);
            end
            chk($sformatf("vec%0d_strobes", v), pv_cnt, vecs[v].exp_pv);
            chk($sformatf("vec%0d_multi", v), mp_cnt, vecs[v].exp_mp);
            chk($sformatf("vec%0d_code", v), int'(player_button), vecs[v].exp_code);
            chk($sformatf("vec%0d_latency", v), ev_first, vecs[v].exp_first);
            chk($sformatf("vec%0d_released", v), int'(any_pressed), 0);
            run(3);
        end

        // Clean press with release timing observed through any_pressed.
        enable = 1'b1;
        clear_mon();
        btn_blue = 1'b1;
        run(40);
        chk("clean_strobes", pv_cnt, 1);
        chk("clean_latency", pv_first, LAT);
        chk("clean_code", int'(player_button), 2);
        chk("clean_any_held", int'(any_pressed), 1);
        btn_blue = 1'b0;
        clear_mon();
        run(D + 1);
        chk("clean_any_before_fall", int'(any_pressed), 1);
        tick();
        chk("clean_any_after_fall", int'(any_pressed), 0);
        run(5);
        chk("clean_no_second", pv_cnt, 0);

        // Bounce: 5-cycle toggles never reach the debounce threshold.
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            btn_red = (k % 2 == 0);
            run(5);
        end
        chk("bounce_strobes", pv_cnt, 0);
        chk("bounce_multi", mp_cnt, 0);
        chk("bounce_any", int'(any_pressed), 0);
        clear_mon();
        btn_red = 1'b1;
        run(25);
        chk("bounce_hold_latency", pv_first, LAT);
        chk("bounce_hold_code", int'(player_button), 0);
        btn_red = 1'b0;
        run(25);

        // Disabled press is discarded; raising enable while held changes nothing.
        enable = 1'b0;
        clear_mon();
        btn_green = 1'b1;
        run(30);
        enable = 1'b1;
        run(10);
        chk("disabled_strobes", pv_cnt, 0);
        chk("disabled_multi", mp_cnt, 0);
        chk("disabled_code", int'(player_button), 0);
        btn_green = 1'b0;
        run(25);
        clear_mon();
        btn_green = 1'b1;
        run(25);
        chk("repress_latency", pv_first, LAT);
        chk("repress_code", int'(player_button), 1);
        btn_green = 1'b0;
        run(25);

        // Late second button is ignored until everything is released.
        clear_mon();
        btn_yellow = 1'b1;
        run(LAT + 5);
        chk("late_first_code", int'(player_button), 3);
        btn_green = 1'b1;
        run(40);
        btn_yellow = 1'b0;
        run(40);
        chk("late_strobes", pv_cnt, 1);
        chk("late_multi", mp_cnt, 0);
        chk("late_any_green_held", int'(any_pressed), 1);
        btn_green = 1'b0;
        run(20);
        chk("late_any_released", int'(any_pressed), 0);
        clear_mon();
        btn_red = 1'b1;
        run(25);
        chk("late_next_latency", pv_first, LAT);
        chk("late_next_code", int'(player_button), 0);
        btn_red = 1'b0;
        run(25);

        // Reset in WAIT_RELEASE with blue still held.
        clear_mon();
        btn_blue = 1'b1;
        run(25);
        chk("rst_pre_strobes", pv_cnt, 1);
        chk("rst_pre_code", int'(player_button), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_code", int'(player_button), 0);
        chk("rst_async_any", int'(any_pressed), 0);
        chk("rst_async_valid", int'(press_valid), 0);
        chk("rst_async_multi", int'(multi_press), 0);
        run(2);
        rst_n = 1'b1;
        clear_mon();
        run(25);
        chk("rst_post_latency", pv_first, LAT);
        chk("rst_post_strobes", pv_cnt, 1);
        chk("rst_post_code", int'(player_button), 2);
        btn_blue = 1'b0;
        run(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
